// File: rtl/stream_mux_rr_pkg.sv
// Shared constants, state encoding and sizing helper for the stream_mux_rr block.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Width needed to index nrOfInputs channels (at least one bit).
  function automatic int unsigned sel_bits_f(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Producer-side and consumer-side stream signals of stream_mux_rr.
interface stream_mux_rr_if #(
  parameter int unsigned nrOfBits   = 8,
  parameter int unsigned nrOfInputs = 4,
  parameter int unsigned selBits    = 2
);
  logic [nrOfInputs*nrOfBits-1:0] muxIn;
  logic [nrOfInputs-1:0]          inValid;
  logic [nrOfInputs-1:0]          inReady;
  logic [nrOfBits-1:0]            muxOut;
  logic                           outValid;
  logic                           outReady;
  logic [selBits-1:0]             outChan;

  modport master (
    output muxIn, inValid, outReady,
    input  inReady, muxOut, outValid, outChan
  );

  modport slave (
    input  muxIn, inValid, outReady,
    output inReady, muxOut, outValid, outChan
  );
endinterface

// File: rtl/stream_mux_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_i, wrapping.
module rr_priority_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] last_i,
  output logic [SW-1:0] cand_o,
  output logic          found_o
);

  int unsigned idx;

  always_comb begin
    cand_o  = '0;
    found_o = 1'b0;
    idx     = 0;
    // Nearest index after last_i wins; step N lands back on last_i itself.
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_i) + i) % N;
      if (!found_o && req_i[idx]) begin
        found_o = 1'b1;
        cand_o  = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream mux with registered output, fixed or round-robin select.
// Optional counters (grantCount, stallCycles) under STREAM_MUX_RR_STATS_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned nrOfBits   = 8,
  parameter int unsigned nrOfInputs = 4,
  parameter int unsigned selBits    = sel_bits_f(nrOfInputs)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic [selBits-1:0] sel,
  stream_mux_rr_if.slave     bus
`ifdef STREAM_MUX_RR_STATS_EN
  ,
  output logic [15:0]        grantCount,
  output logic [15:0]        stallCycles
`endif
);

  state_e                  state_q, state_d;
  logic [nrOfBits-1:0]     data_q, data_d;
  logic [selBits-1:0]      chan_q, chan_d;
  logic [selBits-1:0]      last_q, last_d;
  logic [nrOfInputs-1:0]   sel_mask;
  logic [nrOfInputs-1:0]   req;
  logic [nrOfInputs-1:0]   ready_c;
  logic [selBits-1:0]      cand;
  logic                    found;
  logic                    slot_free;
  logic                    grant;

  // An out-of-range sel matches no bit, so fixed mode then has no candidate.
  always_comb begin
    sel_mask = '0;
    for (int unsigned k = 0; k < nrOfInputs; k++) begin
      sel_mask[k] = (selBits'(k) == sel);
    end
  end

  assign req = (mode == MODE_RR) ? bus.inValid : (bus.inValid & sel_mask);

  rr_priority_pick #(
    .N  (nrOfInputs),
    .SW (selBits)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .cand_o  (cand),
    .found_o (found)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= selBits'(nrOfInputs - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    chan_d    = chan_q;
    last_d    = last_q;
    ready_c   = '0;
    slot_free = (state_q == ST_EMPTY) || bus.outReady;
    grant     = enable && slot_free && found && !reset;

    if (grant) begin
      ready_c[cand] = 1'b1;
      data_d        = bus.muxIn[32'(cand)*nrOfBits +: nrOfBits];
      chan_d        = cand;
      if (mode == MODE_RR) begin
        last_d = cand;
      end
    end

    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (!grant && bus.outReady) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  assign bus.inReady  = ready_c;
  assign bus.muxOut   = data_q;
  assign bus.outChan  = chan_q;
  assign bus.outValid = (state_q == ST_FULL);

`ifdef STREAM_MUX_RR_STATS_EN
  logic [15:0] grant_cnt_q;
  logic [15:0] stall_cnt_q;

  // Grant count wraps; stall count saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant) begin
        grant_cnt_q <= grant_cnt_q + 16'd1;
      end
      if (state_q == ST_FULL && !bus.outReady && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign grantCount  = grant_cnt_q;
  assign stallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: reference model predicts grants, monitor checks delivered words.
module tb_stream_mux_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SB = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [SB-1:0] chan;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          mode;
  logic [SB-1:0] sel;
`ifdef STREAM_MUX_RR_STATS_EN
  logic [15:0]   gc;
  logic [15:0]   sc;
`endif

  stream_mux_rr_if #(.nrOfBits(W), .nrOfInputs(N), .selBits(SB)) bus ();

  stream_mux_rr #(.nrOfBits(W), .nrOfInputs(N), .selBits(SB)) dut (
    .clock       (clk),
    .reset       (rst),
    .enable      (enable),
    .mode        (mode),
    .sel         (sel),
    .bus         (bus)
`ifdef STREAM_MUX_RR_STATS_EN
    ,
    .grantCount  (gc),
    .stallCycles (sc)
`endif
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference state: is a word held, and which channel was granted last in RR mode.
  bit          m_full = 0;
  int          m_last = N - 1;
  logic [15:0] m_grants = 0;
  logic [15:0] m_stall  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: decides the grant from the arbitration rules each cycle.
  always @(negedge clk) begin : model
    logic [N-1:0] er;
    int           c;
    logic [W-1:0] d;
    er = '0;
    c  = -1;
    if (rst) begin
      chk("ready_in_reset", 32'(bus.inReady), 32'd0);
      m_full = 0;
      m_last = N - 1;
      m_grants = 0;
      m_stall  = 0;
      sb.delete();
    end else begin
      chk("out_valid", 32'(bus.outValid), 32'(m_full));
      if (enable && (!m_full || bus.outReady)) begin
        if (mode == 1'b0) begin
          if (int'(sel) < N && bus.inValid[sel]) c = int'(sel);
        end else begin
          for (int s = 1; s <= N; s++) begin
            if (c < 0 && bus.inValid[(m_last + s) % N]) c = (m_last + s) % N;
          end
        end
      end
      if (c >= 0) er[c] = 1'b1;
      chk("in_ready", 32'(bus.inReady), 32'(er));
      if (m_full && !bus.outReady && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (c >= 0) begin
        d = bus.muxIn[c*W +: W];
        sb.push_back('{data: d, chan: SB'(c)});
        m_full   = 1;
        m_grants = m_grants + 16'd1;
        if (mode == 1'b1) m_last = c;
      end else if (m_full && bus.outReady) begin
        m_full = 0;
      end
    end
  end

  // Monitor: every completed output handshake must match the oldest expected word.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual=word chan %0d expected=no word at %0t", bus.outChan, $time);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(bus.muxOut), 32'(e.data));
        chk("out_chan", 32'(bus.outChan), 32'(e.chan));
      end
    end
  end

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    mode         = 1'b1;
    sel          = '0;
    bus.inValid  = 4'hF;
    bus.muxIn    = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.outReady = 1'b1;
    tick(3);
    chk("rst_valid", 32'(bus.outValid), 32'd0);
    chk("rst_data", 32'(bus.muxOut), 32'd0);
    chk("rst_chan", 32'(bus.outChan), 32'd0);
    chk("rst_ready", 32'(bus.inReady), 32'd0);

    // First grant after reset goes to channel 0, then strict rotation.
    rst = 1'b0;
    tick(1);
    chk("first_valid", 32'(bus.outValid), 32'd1);
    chk("first_data", 32'(bus.muxOut), 32'h11);
    chk("first_chan", 32'(bus.outChan), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chk("rr_valid", 32'(bus.outValid), 32'd1);
      chk("rr_chan", 32'(bus.outChan), 32'(i % N));
    end

    bus.inValid = '0;
    tick(2);

    // Fixed select on channel 2 with a stalled consumer.
    mode         = 1'b0;
    sel          = 2'd2;
    bus.inValid  = 4'b0100;
    bus.outReady = 1'b0;
    tick(1);
    chk("fix_valid", 32'(bus.outValid), 32'd1);
    chk("fix_data", 32'(bus.muxOut), 32'h33);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("stall_data", 32'(bus.muxOut), 32'h33);
      chk("stall_ready", 32'(bus.inReady), 32'd0);
    end
    bus.inValid  = '0;
    bus.outReady = 1'b1;
    tick(1);
    chk("drain_valid", 32'(bus.outValid), 32'd0);

    // Selected channel idle: no grant although others are valid.
    bus.inValid = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("nosel_valid", 32'(bus.outValid), 32'd0);
      chk("nosel_ready", 32'(bus.inReady), 32'd0);
    end

    // Dropping enable while full still drains the held word.
    mode         = 1'b1;
    bus.inValid  = 4'hF;
    bus.outReady = 1'b0;
    tick(1);
    chk("en_full", 32'(bus.outValid), 32'd1);
    enable       = 1'b0;
    bus.outReady = 1'b1;
    tick(1);
    chk("en_drain", 32'(bus.outValid), 32'd0);
    tick(2);
    chk("en_hold", 32'(bus.outValid), 32'd0);
    enable = 1'b1;
    tick(1);
    chk("en_resume", 32'(bus.outValid), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(199) == 0);
      enable       = ($urandom_range(9) != 0);
      mode         = 1'($urandom_range(1));
      sel          = SB'($urandom_range(N - 1));
      bus.inValid  = N'($urandom);
      bus.muxIn    = (N*W)'($urandom);
      bus.outReady = ($urandom_range(3) != 0);
      tick(1);
    end

`ifdef STREAM_MUX_RR_STATS_EN
    chk("grant_count", 32'(gc), 32'(m_grants));
    chk("stall_cycles", 32'(sc), 32'(m_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer with one registered output stage.
- Uses a valid/ready handshake on every input and on the output.
- Supports two select modes: fixed (external `sel`) and round-robin arbitration.
- Sits between several producer channels and a single consumer bus. It replaces the enable/sel combinational bus muxes where backpressure and fairness are needed.

Parameters:
- nrOfBits, 8: data width per channel.
- nrOfInputs, 4: channel count, 2..16.
- selBits, 2: select/channel-index width; must equal ceil(log2(nrOfInputs)).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = new grants allowed; 0 = no new grants, but a held output still drains.
- mode  in  1  0 = fixed select; 1 = round-robin.
- sel  in  selBits  channel index used in fixed mode.
- muxIn  in  nrOfInputs*nrOfBits  flattened input data; channel k occupies bits [k*nrOfBits +: nrOfBits].
- inValid  in  nrOfInputs  per-channel valid.
- inReady  out  nrOfInputs  per-channel ready; combinational, one-hot or zero.
- muxOut  out  nrOfBits  registered output data.
- outValid  out  1  output holds data.
- outReady  in  1  consumer accepts data.
- outChan  out  selBits  channel index of the data in muxOut.

Behaviour:
- Reset (synchronous, active-high; clock and reset as named above):
  - outValid=0, muxOut=0, outChan=0.
  - Round-robin pointer last=nrOfInputs-1, so channel 0 has first priority.
  - State=EMPTY.
  - Reset asserted mid-transfer discards held data. inReady is 0 while reset is high.
- State machine:
  - States are EMPTY (outValid=0) and FULL (outValid=1).
  - slotFree = EMPTY | (FULL & outReady).
- Candidate selection (combinational):
  - Fixed mode: cand = sel, provided sel < nrOfInputs and inValid[sel]=1. If sel >= nrOfInputs, there is no candidate and all inReady are 0.
  - Round-robin mode: cand = first k with inValid[k]=1, searching last+1, last+2, … modulo nrOfInputs.
- Grant:
  - grant = enable & slotFree & candidate exists.
  - inReady[cand]=grant; all other inReady bits are 0.
  - An input transfer occurs when inValid[k] & inReady[k].
- On a grant edge:
  - muxOut <= muxIn[cand]; outChan <= cand; outValid <= 1.
  - In round-robin mode, last <= cand. The pointer is not updated in fixed mode.
- Output handshake:
  - FULL & outReady & !grant -> EMPTY (outValid=0; muxOut and outChan keep their old values).
  - FULL & outReady & grant -> stays FULL with the new data. This gives back-to-back throughput of 1 word/cycle.
  - FULL & !outReady -> muxOut and outChan held stable; inReady all 0.
- Latency: one cycle from an input transfer to outValid.
- Mode or sel changes take effect at the next grant decision; the held word is unaffected.
- enable=0 while FULL: the held word still completes when outReady=1, and the block then goes EMPTY.
- Round-robin fairness: with all channels continuously valid, the grant sequence is 0,1,…,N-1,0,…
- Round-robin wrap: last=N-1 wraps the search to channel 0.

Optional Feature:
- Macro: STREAM_MUX_RR_STATS_EN.
- When defined:
  - Adds output grantCount[15:0], a free-running count of grants that wraps at 0xFFFF -> 0x0000. Reset value is 0.
  - Adds output stallCycles[15:0], counting cycles with FULL & !outReady. It saturates at 0xFFFF and resets to 0.
- When not defined: neither port exists and no counter logic is present. Datapath behaviour is identical either way.

Decomposition:
- Package stream_mux_pkg contains:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - State encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
  - A function computing selBits from nrOfInputs.
- One sub-module, rr_priority_pick: purely combinational. Inputs are the request vector and `last`; outputs are cand and a found flag. It is reused for the fixed mode by masking requests to the single sel bit.

Test Plan (nrOfInputs=4, nrOfBits=8):
- Reset with inValid=4'hF, muxIn={8'h44,8'h33,8'h22,8'h11} -> outValid=0, muxOut=0, inReady=0 during reset. First grant after release is channel 0: muxOut=8'h11, outChan=0.
- mode=1, all valid, outReady=1 for 8 cycles -> outChan sequence 0,1,2,3,0,1,2,3 and one word per cycle.
- mode=0, sel=2, inValid=4'b0100, outReady=0 for 3 cycles -> muxOut=8'h33 held stable. inReady=0 while stalled. Output drains on the first cycle outReady=1.
- mode=0, sel=2, inValid=4'b1011 -> no grant, outValid stays 0, inReady=0.
- enable dropped while FULL with outReady=1 -> word delivered, outValid=0 next cycle, no further grants until enable=1.
- STREAM_MUX_RR_STATS_EN defined, 5 grants with 2 stall cycles -> grantCount=5, stallCycles=2. Preloading to 0xFFFF checks grantCount wrap to 0 and stallCycles holding at 0xFFFF.
